// File: rtl/one_hot_mux_pipe.sv
// AND-OR one-hot multiplexer followed by a DEPTH-stage valid/ready pipeline.
// Optionally counts accepted multi-hot selects into a sticky flag and a saturating counter.
module one_hot_mux_pipe #(
  parameter int WIDTH         = 32,
  parameter int CNT           = 5,
  parameter int DEPTH         = 2,
  parameter int ONE_HOT_CHECK = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH*CNT-1:0] din,
  input  logic [CNT-1:0]       sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     dout,
  output logic                 out_hit,
  input  logic                 err_clr,
  output logic                 err_sticky,
  output logic [7:0]           err_cnt
);

  function automatic logic [WIDTH-1:0] and_or_mux(input logic [WIDTH*CNT-1:0] d,
                                                  input logic [CNT-1:0]       s);
    logic [WIDTH-1:0] acc;
    acc = '0;
    for (int k = 0; k < CNT; k++) begin
      acc = acc | (d[k*WIDTH +: WIDTH] & {WIDTH{s[k]}});
    end
    return acc;
  endfunction

  function automatic logic multi_hot(input logic [CNT-1:0] s);
    return (s & (s - CNT'(1))) != '0;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] hit_q, hit_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] stg_rdy;
  logic             accept;

  // A stage can take a beat when empty or when its successor is draining.
  always_comb begin : ready_chain
    logic rdy;
    rdy = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy        = !vld_q[i] || rdy;
      stg_rdy[i] = rdy;
    end
  end

  always_comb begin
    vld_d = vld_q;
    hit_d = hit_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    // stage 0: mux result capture
    if (stg_rdy[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = and_or_mux(din, sel);
        hit_d[0]  = |sel;
      end
    end
    // stages 1..DEPTH-1: shift forward
    for (int i = 1; i < DEPTH; i++) begin
      if (stg_rdy[i]) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) begin
          data_d[i] = data_q[i-1];
          hit_d[i]  = hit_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      hit_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      hit_q <= hit_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign in_ready  = stg_rdy[0];
  assign out_valid = vld_q[DEPTH-1];
  assign dout      = data_q[DEPTH-1];
  assign out_hit   = hit_q[DEPTH-1];
  assign accept    = in_valid && in_ready;

  if (ONE_HOT_CHECK != 0) begin : g_chk
    logic       err_sticky_q, err_sticky_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       bad_accept;

    assign bad_accept = accept && multi_hot(sel);

    // A clear that coincides with a bad accept restarts the count at one.
    always_comb begin
      err_sticky_d = err_sticky_q;
      err_cnt_d    = err_cnt_q;
      if (err_clr) begin
        err_sticky_d = bad_accept;
        err_cnt_d    = bad_accept ? 8'd1 : 8'd0;
      end else if (bad_accept) begin
        err_sticky_d = 1'b1;
        err_cnt_d    = sat_inc(err_cnt_q);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        err_sticky_q <= 1'b0;
        err_cnt_q    <= 8'd0;
      end else begin
        err_sticky_q <= err_sticky_d;
        err_cnt_q    <= err_cnt_d;
      end
    end

    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
  end else begin : g_nochk
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_sticky     = 1'b0;
    assign err_cnt        = 8'd0;
  end

endmodule

// File: tb/tb_one_hot_mux_pipe.sv
// Directed bench for one_hot_mux_pipe (WIDTH=8, CNT=4, DEPTH=2), checking both
// the select-checking and non-checking builds driven from the same inputs.
module tb_one_hot_mux_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] din = '0;
  logic [3:0]  sel = '0;
  logic        out_ready = 1'b1;
  logic        err_clr = 1'b0;

  logic        in_ready0, out_valid0, out_hit0, err_sticky0;
  logic [7:0]  dout0, err_cnt0;
  logic        in_ready1, out_valid1, out_hit1, err_sticky1;
  logic [7:0]  dout1, err_cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  one_hot_mux_pipe #(.WIDTH(8), .CNT(4), .DEPTH(2), .ONE_HOT_CHECK(1)) u_chk (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .din(din), .sel(sel), .out_valid(out_valid0), .out_ready(out_ready),
    .dout(dout0), .out_hit(out_hit0), .err_clr(err_clr),
    .err_sticky(err_sticky0), .err_cnt(err_cnt0)
  );

  one_hot_mux_pipe #(.WIDTH(8), .CNT(4), .DEPTH(2), .ONE_HOT_CHECK(0)) u_nochk (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .din(din), .sel(sel), .out_valid(out_valid1), .out_ready(out_ready),
    .dout(dout1), .out_hit(out_hit1), .err_clr(err_clr),
    .err_sticky(err_sticky1), .err_cnt(err_cnt1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] din;
    logic [3:0]  sel;
    logic [7:0]  exp_dout;
    logic        exp_hit;
    logic        multi;
  } vec_t;

  vec_t vt[9];
  int   exp_cnt = 0;
  logic exp_sticky = 1'b0;

  initial begin
    int   sent, recv;
    logic held_v;
    logic [7:0] held_d;
    logic [7:0] exp_q[$];

    vt[0] = '{32'h44332211, 4'b0100, 8'h33, 1'b1, 1'b0};
    vt[1] = '{32'h44332211, 4'b0001, 8'h11, 1'b1, 1'b0};
    vt[2] = '{32'h44332211, 4'b1000, 8'h44, 1'b1, 1'b0};
    vt[3] = '{32'h44332211, 4'b0011, 8'h33, 1'b1, 1'b1};
    vt[4] = '{32'h44332211, 4'b0000, 8'h00, 1'b0, 1'b0};
    vt[5] = '{32'h44332211, 4'b1111, 8'h77, 1'b1, 1'b1};
    vt[6] = '{32'hF00FA55A, 4'b0101, 8'h5F, 1'b1, 1'b1};
    vt[7] = '{32'hF00FA55A, 4'b1010, 8'hF5, 1'b1, 1'b1};
    vt[8] = '{32'hF00FA55A, 4'b0010, 8'hA5, 1'b1, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_dout", dout0, 0);
    chk("rst_out_hit", out_hit0, 0);
    chk("rst_err_sticky", err_sticky0, 0);
    chk("rst_err_cnt", err_cnt0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready0, 1);

    // single beats: latency, mux result, error tracking
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; din = vt[i].din; sel = vt[i].sel; out_ready = 1'b1;
      @(negedge clk);
      chk("vec_in_ready", in_ready0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; din = $urandom; sel = 4'b1111;
      if (vt[i].multi) begin
        exp_sticky = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
      end
      @(negedge clk);
      chk("vec_early_valid", out_valid0, 0);
      chk("vec_err_cnt", err_cnt0, exp_cnt);
      chk("vec_err_sticky", err_sticky0, exp_sticky);
      chk("vec_nochk_sticky", err_sticky1, 0);
      @(negedge clk);
      chk("vec_out_valid", out_valid0, 1);
      chk("vec_dout", dout0, vt[i].exp_dout);
      chk("vec_out_hit", out_hit0, vt[i].exp_hit);
      chk("vec_nochk_dout", dout1, vt[i].exp_dout);
      chk("vec_nochk_hit", out_hit1, vt[i].exp_hit);
      chk("vec_nochk_valid", out_valid1, 1);
      chk("vec_nochk_ready", in_ready1, 1);
      @(negedge clk);
      chk("vec_single_beat", out_valid0, 0);
      chk("vec_err_cnt_hold", err_cnt0, exp_cnt);
    end
    chk("nochk_err_cnt", err_cnt1, 0);

    // streaming under backpressure (out_ready low for cycles 2..5)
    sent = 0; recv = 0; held_v = 1'b0; held_d = '0;
    for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      @(posedge clk); #1;
      in_valid  = (sent < 6);
      sel       = 4'(1 << (sent % 4));
      din       = {8'(sent*16+3), 8'(sent*16+2), 8'(sent*16+1), 8'(sent*16)};
      out_ready = !(cyc >= 2 && cyc <= 5);
      @(negedge clk);
      if (held_v) begin
        chk("stall_valid_hold", out_valid0, 1);
        chk("stall_dout_hold", dout0, held_d);
      end
      if (cyc == 2) chk("stall_in_ready", in_ready0, 0);
      if (out_valid0 && out_ready) begin
        if (exp_q.size() == 0) chk("stream_extra_beat", 1, 0);
        else begin
          chk("stream_order", dout0, exp_q.pop_front());
          recv++;
        end
      end
      held_v = out_valid0 && !out_ready;
      held_d = dout0;
      if (in_valid && in_ready0) begin
        exp_q.push_back(8'(sent*16 + sent % 4));
        sent++;
      end
    end
    in_valid = 1'b0;
    chk("stream_delivered", recv, 6);

    // multi-hot presented while stalled is not checked
    @(posedge clk); #1;
    in_valid = 1'b1; sel = 4'b0001; din = 32'h44332211; out_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    sel = 4'b0011;
    @(negedge clk);
    chk("full_in_ready", in_ready0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("unaccepted_err_cnt", err_cnt0, exp_cnt);
    repeat (3) @(posedge clk);

    // clear, then saturate the counter
    #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("clr_err_cnt", err_cnt0, 0);
    chk("clr_err_sticky", err_sticky0, 0);
    @(posedge clk); #1;
    in_valid = 1'b1; sel = 4'b0011; out_ready = 1'b1;
    repeat (300) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("sat_err_cnt", err_cnt0, 8'hFF);
    chk("sat_err_sticky", err_sticky0, 1);

    // clear coinciding with a multi-hot accept
    @(posedge clk); #1;
    in_valid = 1'b1; sel = 4'b0011; err_clr = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    chk("clr_coinc_sticky", err_sticky0, 1);
    chk("clr_coinc_cnt", err_cnt0, 1);
    chk("clr_coinc_nochk", err_sticky1, 0);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("clr_alone_cnt", err_cnt0, 0);
    chk("clr_alone_sticky", err_sticky0, 0);
    repeat (3) @(posedge clk);

    // asynchronous reset with two beats in flight
    #1;
    in_valid = 1'b1; sel = 4'b0100; din = 32'h44332211; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("inflight_valid", out_valid0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid0, 0);
    chk("async_rst_dout", dout0, 0);
    chk("async_rst_in_ready", in_ready0, 1);
    @(posedge clk); #3;
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_stale", out_valid0, 0);
      chk("post_rst_ready", in_ready0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/one_hot_mux_pipe.md
ONE_HOT_MUX_PIPE -- requirements
Module: one_hot_mux_pipe

Interface
REQ-001 Parameter WIDTH, default 32, bit width of each data channel (>=1).
REQ-002 Parameter CNT, default 5, number of input channels (>=2).
REQ-003 Parameter DEPTH, default 2, number of register stages from input to output (1..8).
REQ-004 Parameter ONE_HOT_CHECK, default 1; 1 enables select-legality checking, 0 ties all error outputs to 0.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  input beat present.
REQ-008 in_ready  output  1  block accepts the beat this cycle.
REQ-009 din  input  WIDTH*CNT  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 sel  input  CNT  one-hot channel select, bit k selects channel k.
REQ-011 out_valid  output  1  output beat present.
REQ-012 out_ready  input  1  downstream accepts the output beat.
REQ-013 dout  output  WIDTH  selected data of the output beat.
REQ-014 out_hit  output  1  the output beat had at least one select bit set (|sel).
REQ-015 err_clr  input  1  synchronous clear of the error status.
REQ-016 err_sticky  output  1  a multi-hot select has been accepted since the last clear.
REQ-017 err_cnt  output  8  count of accepted multi-hot beats, saturating at 8'hFF.

Function
REQ-018 The mux SHALL be AND-OR: dout = OR over k of (din channel k AND replicated sel[k]); sel==0 yields all zeros; multi-hot yields the bitwise OR of the selected channels.
REQ-019 The pipeline SHALL hold DEPTH stages; each stage holds a valid bit, WIDTH data bits and the hit bit; the mux result is captured into stage 0.
REQ-020 Stage i SHALL be ready when it is empty or stage i+1 is ready; the ready of the last stage SHALL be out_ready; in_ready SHALL be the ready of stage 0 (a combinational out_ready-to-in_ready path is permitted).
REQ-021 A beat SHALL be accepted when in_valid && in_ready; it SHALL be transferred out when out_valid && out_ready.
REQ-022 With out_ready held high, latency SHALL be exactly DEPTH cycles from acceptance to out_valid, with throughput of one beat per cycle.
REQ-023 Under backpressure, out_valid, dout and out_hit SHALL hold stable until the beat is transferred; no beat SHALL be dropped, duplicated or reordered.
REQ-024 Simultaneous accept and transfer SHALL be allowed when all stages are full; occupancy remains DEPTH.
REQ-025 A beat with sel==0 SHALL be accepted and delivered with dout=0 and out_hit=0; it is not an error.
REQ-026 When ONE_HOT_CHECK=1, an accepted beat with more than one sel bit set SHALL set err_sticky and increment err_cnt (saturating) on the acceptance edge; unaccepted beats SHALL not be checked.
REQ-027 If err_clr and a multi-hot accept coincide, err_sticky SHALL be 1 and err_cnt SHALL be 1 on the next cycle; err_clr alone SHALL zero both.
REQ-028 din and sel SHALL be ignored when in_valid=0.

Reset
REQ-029 While rst_n=0: all stage valid bits, dout, out_hit, err_sticky and err_cnt SHALL be 0; out_valid=0; in_ready=1 from the first clock edge after deassertion.
REQ-030 Assertion of rst_n mid-operation SHALL discard all in-flight beats immediately (asynchronously), with no partial beat emitted afterward.

Verification (WIDTH=8, CNT=4, DEPTH=2)
REQ-031 din={8'h44,8'h33,8'h22,8'h11}, sel=4'b0100, 1-cycle valid, out_ready=1 -> out_valid exactly 2 cycles later, dout=8'h33, out_hit=1.
REQ-032 Stream 6 beats with out_ready=0 for cycles 2..5 -> in_ready falls after 2 beats are held; all 6 delivered in order with stable outputs while stalled.
REQ-033 sel=4'b0011 accepted -> dout=8'h33 (8'h11|8'h22), err_sticky=1, err_cnt=1; repeat 300 times -> err_cnt=8'hFF.
REQ-034 sel=4'b0000 accepted -> dout=8'h00, out_hit=0, err_cnt unchanged; ONE_HOT_CHECK=0 with sel=4'b1111 -> err_sticky stays 0.
REQ-035 err_clr pulsed in the same cycle as a multi-hot accept -> err_sticky=1, err_cnt=1.
REQ-036 rst_n asserted with 2 beats in flight -> out_valid=0 immediately; after release, no stale beat appears and in_ready=1.
